// File: rtl/snax_exercise_job_sched_pkg.sv
// snax_exercise_sched_pkg: shared job record, scheduler states and CSR constants.
// job_t is sized for the default build (32-bit CSR data, two requesters).
package snax_exercise_sched_pkg;
  localparam int JobDataW = 32;
  localparam int JobReqs = 2;
  localparam int JobIdW = JobReqs > 1 ? $clog2(JobReqs) : 1;
  localparam logic [JobDataW-1:0] CsrStartValue = JobDataW'(1);
  typedef struct packed {
    logic [JobIdW-1:0] id;
    logic [JobDataW-1:0] upper;
    logic [JobDataW-1:0] lower;
    logic [JobDataW-1:0] len;
  } job_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, REPORT} sched_state_e;
endpackage

// File: rtl/snax_exercise_job_sched_if.sv
// snax_exercise_job_sched_if: requester, CSR, accelerator, completion and status signals of the job scheduler.
// SNAX_EXERCISE_SCHED_STATS_EN adds the per-requester job and reject counters.
interface snax_exercise_job_sched_if #(
  parameter int RegDataWidth = 32,
  parameter int NumReq = 2,
  parameter int JobDepth = 4,
  parameter int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
);
  logic [NumReq-1:0] req_valid, req_ready;
  logic [NumReq-1:0][RegDataWidth-1:0] req_upper, req_lower, req_len;
  logic [RegDataWidth-1:0] csr_upper, csr_lower, csr_len, csr_start;
  logic csr_valid, csr_ready, acc_busy;
  logic [RegDataWidth-1:0] acc_perf;
  logic done_valid, done_err;
  logic [IdWidth-1:0] done_id;
  logic [RegDataWidth-1:0] done_perf;
  logic [$clog2(JobDepth):0] fifo_count;
  logic sched_idle;
`ifdef SNAX_EXERCISE_SCHED_STATS_EN
  logic [NumReq-1:0][RegDataWidth-1:0] stat_jobs;
  logic [RegDataWidth-1:0] stat_rejects;
`endif
  modport slave (
    input req_valid, req_upper, req_lower, req_len, csr_ready, acc_busy, acc_perf,
    output req_ready, csr_upper, csr_lower, csr_len, csr_start, csr_valid,
    output done_valid, done_id, done_err, done_perf, fifo_count, sched_idle
`ifdef SNAX_EXERCISE_SCHED_STATS_EN
    , output stat_jobs, stat_rejects
`endif
  );
  modport master (
    output req_valid, req_upper, req_lower, req_len, csr_ready, acc_busy, acc_perf,
    input req_ready, csr_upper, csr_lower, csr_len, csr_start, csr_valid,
    input done_valid, done_id, done_err, done_perf, fifo_count, sched_idle
`ifdef SNAX_EXERCISE_SCHED_STATS_EN
    , input stat_jobs, stat_rejects
`endif
  );
endinterface

// File: rtl/snax_exercise_job_sched_rr_arb.sv
// snax_exercise_rr_arb: round-robin grant of the first requester at or after the pointer.
module snax_exercise_rr_arb #(
  parameter int NumReq = 2,
  parameter int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NumReq-1:0] req,
  input  logic en,
  output logic [NumReq-1:0] gnt,
  output logic [IdWidth-1:0] idx
);
  logic [IdWidth-1:0] ptr;
  // Scanning from the far end lets the closest requester after ptr overwrite the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NumReq - 1; k >= 0; k--)
      if (en && req[IdWidth'((int'(ptr) + k) % NumReq)]) begin
        gnt = '0;
        gnt[IdWidth'((int'(ptr) + k) % NumReq)] = 1'b1;
        idx = IdWidth'((int'(ptr) + k) % NumReq);
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (|gnt) ptr <= IdWidth'((int'(idx) + 1) % NumReq);
endmodule

// File: rtl/snax_exercise_job_sched.sv
// snax_exercise_job_sched: round-robin job intake, job FIFO and single-job CSR issue/complete sequencer.
// SNAX_EXERCISE_SCHED_STATS_EN adds completed-job and rejected-job counters.
module snax_exercise_job_sched
  import snax_exercise_sched_pkg::*;
#(
  parameter int RegDataWidth = JobDataW,
  parameter int NumReq = JobReqs,
  parameter int JobDepth = 4,
  parameter int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input logic clk_i,
  input logic rst_i,
  snax_exercise_job_sched_if.slave bus
);
  localparam int AddrW = $clog2(JobDepth);
  localparam int CntW = AddrW + 1;
  job_t mem [JobDepth];
  job_t job;
  logic [AddrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic [NumReq-1:0] gnt;
  logic [IdWidth-1:0] gnt_idx;
  logic push, pop, full;
  sched_state_e state;
  assign full = count == CntW'(JobDepth);
  assign push = |gnt;
  assign pop = state == IDLE && count != '0;
  assign bus.req_ready = gnt;
  assign bus.fifo_count = count;
  assign bus.sched_idle = state == IDLE && count == '0;
  assign bus.csr_upper = job.upper[RegDataWidth-1:0];
  assign bus.csr_lower = job.lower[RegDataWidth-1:0];
  assign bus.csr_len = job.len[RegDataWidth-1:0];
  snax_exercise_rr_arb #(.NumReq(NumReq), .IdWidth(IdWidth)) u_arb (
    .clk(clk_i), .rst(rst_i), .req(bus.req_valid), .en(!full), .gnt(gnt), .idx(gnt_idx)
  );
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= '{id: JobIdW'(gnt_idx), upper: JobDataW'(bus.req_upper[gnt_idx]),
                               lower: JobDataW'(bus.req_lower[gnt_idx]), len: JobDataW'(bus.req_len[gnt_idx])};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AddrW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AddrW'(1) : rd_ptr;
      count <= count + CntW'(push) - CntW'(pop);
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      job <= '0;
      bus.csr_valid <= 1'b0;
      bus.csr_start <= '0;
      bus.done_valid <= 1'b0;
      bus.done_id <= '0;
      bus.done_err <= 1'b0;
      bus.done_perf <= '0;
    end else begin
      bus.done_valid <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          job <= mem[rd_ptr];
          bus.csr_start <= CsrStartValue[RegDataWidth-1:0];
          // Zero-length jobs never reach the accelerator; they complete as rejects.
          if (mem[rd_ptr].len == '0) begin
            state <= REPORT;
            bus.done_valid <= 1'b1;
            bus.done_id <= IdWidth'(mem[rd_ptr].id);
            bus.done_err <= 1'b1;
            bus.done_perf <= '0;
          end else begin
            state <= ISSUE;
            bus.csr_valid <= 1'b1;
          end
        end
        ISSUE: if (bus.csr_ready) begin
          bus.csr_valid <= 1'b0;
          state <= WAIT_START;
        end
        WAIT_START: if (bus.acc_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!bus.acc_busy) begin
          state <= REPORT;
          bus.done_valid <= 1'b1;
          bus.done_id <= IdWidth'(job.id);
          bus.done_err <= 1'b0;
          bus.done_perf <= bus.acc_perf;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SNAX_EXERCISE_SCHED_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus.stat_jobs <= '0;
      bus.stat_rejects <= '0;
    end else if (state == REPORT) begin
      if (bus.done_err) bus.stat_rejects <= bus.stat_rejects + RegDataWidth'(1);
      else bus.stat_jobs[bus.done_id] <= bus.stat_jobs[bus.done_id] + RegDataWidth'(1);
    end
`endif
endmodule
